// File: rtl/pkt_gen_param_if.sv
// Bus between the packet generator and the router input port.
// Handshake: a word moves on a rising edge where packet_gen_valid=1 and stop_packet=0; while stop_packet=1 the word is held.
interface pkt_gen_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                  start_packet_gen;
    logic [DATA_WIDTH-1:0] srcid;
    logic [DATA_WIDTH-1:0] dstid;
    logic [SIZE_WIDTH-1:0] actual_size;
    logic                  stop_packet;
    logic [DATA_WIDTH-1:0] packet_gen_output;
    logic                  packet_gen_valid;
    logic                  packet_starting;
    logic                  packet_ending;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  packets_sent;
    logic [2:0]            state_dbg;

    modport master (
        input  start_packet_gen, srcid, dstid, actual_size, stop_packet,
        output packet_gen_output, packet_gen_valid, packet_starting,
               packet_ending, busy, packets_sent, state_dbg
    );

    modport slave (
        output start_packet_gen, srcid, dstid, actual_size, stop_packet,
        input  packet_gen_output, packet_gen_valid, packet_starting,
               packet_ending, busy, packets_sent, state_dbg
    );
endinterface

// File: rtl/pkt_gen_param.sv
// Framed packet transmitter: src, dst, len, payload, XOR parity, then an idle gap.
// All outputs come straight from flops; state is visible on bus.state_dbg.
module pkt_gen_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int SIZE_WIDTH   = 4,
    parameter int MAX_PAYLOAD  = 7,
    parameter int PAYLOAD_MODE = 0,
    parameter int SEED         = 0,
    parameter int IFG_CYCLES   = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic              clk,
    input  logic              rst,
    pkt_gen_param_if.master   bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SRC  = 3'd1;
    localparam logic [2:0] DST  = 3'd2;
    localparam logic [2:0] LEN  = 3'd3;
    localparam logic [2:0] PAY  = 3'd4;
    localparam logic [2:0] PAR  = 3'd5;
    localparam logic [2:0] GAP  = 3'd6;

    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GW-1:0]         GAP_LAST = GW'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);
    localparam logic [SIZE_WIDTH-1:0] MAX_SZ   = SIZE_WIDTH'(MAX_PAYLOAD);
    localparam logic [DATA_WIDTH-1:0] SEED_V   = DATA_WIDTH'(SEED);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  start_q, start_d;
    logic                  end_q, end_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pay_q, pay_d;
    logic [DATA_WIDTH-1:0] par_q, par_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [SIZE_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dst_q, dst_d;
    logic                  xfer;
    logic                  go;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        start_d = start_q;
        end_d   = end_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        pay_d   = pay_q;
        par_d   = par_q;
        gap_d   = gap_q;
        size_d  = size_q;
        rem_d   = rem_q;
        dst_d   = dst_q;
        go      = 1'b0;
        xfer    = valid_q && !bus.stop_packet;

        case (state_q)
            IDLE: go = bus.start_packet_gen;
            SRC: if (xfer) begin
                state_d = DST;
                out_d   = dst_q;
                start_d = 1'b0;
                par_d   = par_q ^ out_q;
            end
            DST: if (xfer) begin
                state_d = LEN;
                out_d   = DATA_WIDTH'(size_q);
                par_d   = par_q ^ out_q;
            end
            LEN: if (xfer) begin
                par_d = par_q ^ out_q;
                if (size_q != '0) begin
                    state_d = PAY;
                    out_d   = pay_q;
                    rem_d   = size_q - 1'b1;
                end else begin
                    state_d = PAR;
                    out_d   = par_q ^ out_q;
                    end_d   = 1'b1;
                end
            end
            PAY: if (xfer) begin
                par_d = par_q ^ out_q;
                pay_d = pay_q + 1'b1;
                if (rem_q == '0) begin
                    state_d = PAR;
                    out_d   = par_q ^ out_q;
                    end_d   = 1'b1;
                end else begin
                    out_d = pay_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                end
            end
            PAR: if (xfer) begin
                cnt_d   = cnt_q + 1'b1;
                valid_d = 1'b0;
                end_d   = 1'b0;
                out_d   = '0;
                if (IFG_CYCLES == 0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    go      = bus.start_packet_gen;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LAST;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    go      = bus.start_packet_gen;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A held request launches the next packet without spending a cycle in IDLE.
        if (go) begin
            state_d = SRC;
            out_d   = bus.srcid;
            dst_d   = bus.dstid;
            size_d  = (bus.actual_size > MAX_SZ) ? MAX_SZ : bus.actual_size;
            valid_d = 1'b1;
            start_d = 1'b1;
            end_d   = 1'b0;
            busy_d  = 1'b1;
            par_d   = '0;
            if (PAYLOAD_MODE == 1) pay_d = SEED_V;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            pay_q   <= SEED_V;
            par_q   <= '0;
            gap_q   <= '0;
            size_q  <= '0;
            rem_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            start_q <= start_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            par_q   <= par_d;
            gap_q   <= gap_d;
            size_q  <= size_d;
            rem_q   <= rem_d;
            dst_q   <= dst_d;
        end
    end

    assign bus.packet_gen_output = out_q;
    assign bus.packet_gen_valid  = valid_q;
    assign bus.packet_starting   = start_q;
    assign bus.packet_ending     = end_q;
    assign bus.busy              = busy_q;
    assign bus.packets_sent      = cnt_q;
    assign bus.state_dbg         = state_q;
endmodule

// File: tb/tb_pkt_gen_param.sv
// Bench for pkt_gen_param: instance a uses default parameters, instance b uses
// PAYLOAD_MODE=1, SEED=10, IFG_CYCLES=0 and a 2-bit packet counter.
module tb_pkt_gen_param;
    logic clk;
    logic rst;

    pkt_gen_param_if #(.DATA_WIDTH(8), .SIZE_WIDTH(4), .CNT_WIDTH(8)) ifa ();
    pkt_gen_param_if #(.DATA_WIDTH(8), .SIZE_WIDTH(4), .CNT_WIDTH(2)) ifb ();

    pkt_gen_param dut_a (.clk(clk), .rst(rst), .bus(ifa));

    pkt_gen_param #(
        .PAYLOAD_MODE(1), .SEED(10), .IFG_CYCLES(0), .CNT_WIDTH(2)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected words: {packet_starting, packet_ending, word}
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] m_pay_a = 8'd0;
    logic [7:0] m_pay_b = 8'd10;
    int m_cnt_a = 0;
    int m_cnt_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit s, input logic [9:0] v);
        if (s) exp_b.push_back(v);
        else   exp_a.push_back(v);
    endtask

    // Reference packet: header words, payload run, parity over everything before it.
    task automatic model_pkt(input bit s, input logic [7:0] src, input logic [7:0] dst,
                             input logic [3:0] act);
        logic [7:0] w[$];
        logic [7:0] pay;
        logic [7:0] par;
        int sz;
        sz  = (act > 4'd7) ? 7 : int'(act);
        pay = s ? 8'd10 : m_pay_a;
        w.push_back(src);
        w.push_back(dst);
        w.push_back(8'(sz));
        for (int k = 0; k < sz; k++) begin
            w.push_back(pay);
            pay = pay + 8'd1;
        end
        par = 8'd0;
        foreach (w[k]) par = par ^ w[k];
        for (int k = 0; k < w.size(); k++) push_exp(s, {(k == 0), 1'b0, w[k]});
        push_exp(s, {2'b01, par});
        if (s) m_pay_b = pay;
        else   m_pay_a = pay;
    endtask

    task automatic drv(input bit s, input logic st, input logic [7:0] src,
                       input logic [7:0] dst, input logic [3:0] sz);
        if (s) begin
            ifb.start_packet_gen = st; ifb.srcid = src; ifb.dstid = dst; ifb.actual_size = sz;
        end else begin
            ifa.start_packet_gen = st; ifa.srcid = src; ifa.dstid = dst; ifa.actual_size = sz;
        end
    endtask

    task automatic set_stop(input bit s, input logic v);
        if (s) ifb.stop_packet = v;
        else   ifa.stop_packet = v;
    endtask

    function automatic logic o_valid(input bit s);
        return s ? ifb.packet_gen_valid : ifa.packet_gen_valid;
    endfunction

    function automatic logic o_busy(input bit s);
        return s ? ifb.busy : ifa.busy;
    endfunction

    function automatic logic [7:0] o_cnt(input bit s);
        return s ? {6'b0, ifb.packets_sent} : ifa.packets_sent;
    endfunction

    // smode: 0 no backpressure, 1 three stall cycles on the DST word, 2 random stalls
    task automatic send(input bit s, input logic [7:0] src, input logic [7:0] dst,
                        input logic [3:0] act, input int smode);
        int sz, ifg, vcnt, gcnt, nst, idx, it;
        logic stp, xfer;
        bit done;
        sz  = (act > 4'd7) ? 7 : int'(act);
        ifg = s ? 0 : 2;
        model_pkt(s, src, dst, act);
        if (s) m_cnt_b = (m_cnt_b + 1) % 4;
        else   m_cnt_a = (m_cnt_a + 1) % 256;
        drv(s, 1'b1, src, dst, act);
        tick();
        drv(s, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
        vcnt = 0; gcnt = 0; nst = 0; idx = 0; it = 0; done = 0;
        while (!done && it < 300) begin
            if (!o_busy(s)) begin
                done = 1;
            end else begin
                if (o_valid(s)) vcnt++;
                else            gcnt++;
                stp = 1'b0;
                if (smode == 1) stp = (idx == 1 && nst < 3);
                if (smode == 2) stp = ($urandom_range(0, 3) == 0);
                if (stp && o_valid(s)) nst++;
                xfer = o_valid(s) && !stp;
                set_stop(s, stp);
                tick();
                if (xfer) idx++;
                it++;
            end
        end
        set_stop(s, 1'b0);
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL pkt_timeout: busy still %0b after %0d cycles", o_busy(s), it);
        end
        chk(s ? "b_valid_cycles" : "a_valid_cycles", vcnt, sz + 4 + nst);
        chk(s ? "b_gap_cycles" : "a_gap_cycles", gcnt, ifg);
        chk(s ? "b_packets_sent" : "a_packets_sent", o_cnt(s), s ? m_cnt_b : m_cnt_a);
        chk(s ? "b_idle_valid" : "a_idle_valid", o_valid(s), 0);
    endtask

    // Monitors: compare every presented word; pop only once it is accepted.
    always @(negedge clk) begin
        if (ifa.packet_gen_valid === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL a_word: got %0h expected nothing", ifa.packet_gen_output);
            end else begin
                chk("a_word", {ifa.packet_starting, ifa.packet_ending, ifa.packet_gen_output}, exp_a[0]);
                if (!ifa.stop_packet) void'(exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.packet_gen_valid === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL b_word: got %0h expected nothing", ifb.packet_gen_output);
            end else begin
                chk("b_word", {ifb.packet_starting, ifb.packet_ending, ifb.packet_gen_output}, exp_b[0]);
                if (!ifb.stop_packet) void'(exp_b.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] src, dst;
        rst = 1'b1;
        drv(0, 1'b0, 8'h00, 8'h00, 4'h0);
        drv(1, 1'b0, 8'h00, 8'h00, 4'h0);
        set_stop(0, 1'b0);
        set_stop(1, 1'b0);
        repeat (3) tick();
        chk("rst_valid", ifa.packet_gen_valid, 0);
        chk("rst_output", ifa.packet_gen_output, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_count", ifa.packets_sent, 0);
        chk("rst_b_valid", ifb.packet_gen_valid, 0);
        rst = 1'b0;
        tick();

        // Abort during the second payload word.
        model_pkt(0, 8'h3C, 8'h51, 4'd5);
        repeat (4) void'(exp_a.pop_back());
        drv(0, 1'b1, 8'h3C, 8'h51, 4'd5);
        tick();
        drv(0, 1'b0, 8'h00, 8'h00, 4'd0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pay_a = 8'd0;
        chk("abort_valid", ifa.packet_gen_valid, 0);
        chk("abort_output", ifa.packet_gen_output, 0);
        chk("abort_starting", ifa.packet_starting, 0);
        chk("abort_ending", ifa.packet_ending, 0);
        chk("abort_busy", ifa.busy, 0);
        chk("abort_count", ifa.packets_sent, 0);
        tick();

        send(0, 8'h0A, 8'h0A, 4'd5, 0);
        send(0, 8'h0B, 8'h82, 4'd0, 0);
        send(0, 8'h21, 8'h43, 4'd2, 0);
        send(0, 8'h11, 8'h22, 4'd9, 0);
        send(0, 8'h5A, 8'hC3, 4'd4, 1);
        for (int i = 0; i < 20; i++)
            send(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 2);

        // Back-to-back with start held: no idle cycle between packets.
        src = 8'($urandom);
        dst = 8'($urandom);
        model_pkt(1, src, dst, 4'd3);
        model_pkt(1, src, dst, 4'd3);
        m_cnt_b = (m_cnt_b + 2) % 4;
        drv(1, 1'b1, src, dst, 4'd3);
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("b2b_valid", ifb.packet_gen_valid, 1);
            if (k == 1 || k == 8) chk("b2b_starting", ifb.packet_starting, 1);
            if (k == 8) drv(1, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
        end
        tick();
        chk("b2b_end_valid", ifb.packet_gen_valid, 0);
        chk("b2b_end_busy", ifb.busy, 0);
        chk("b2b_count", ifb.packets_sent, m_cnt_b);

        // Counter wraps through 3 -> 0 on the 2-bit instance.
        for (int i = 0; i < 4; i++)
            send(1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 2);

        repeat (4) tick();
        chk("a_queue_empty", exp_a.size(), 0);
        chk("b_queue_empty", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
